rot_arb_seq: RTL and testbench

ROT_ARB_SEQ -- requirements
Module: rot_arb_seq

---
 rtl/rot_arb_seq.sv | 131 +++++++++++++
 tb/tb_rot_arb_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rot_arb_seq.sv
// Two-requester arbiter feeding a multi-cycle 4-bit rotator with a valid/ready result port.
// Optional: define ROT_ARB_RR_EN for round-robin tie-breaking (default is fixed priority, A wins).
module rot_arb_seq (
    input  logic       clk,
    input  logic       rst,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [3:0] a_data,
    input  logic [1:0] a_amt,
    input  logic       a_dir,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [3:0] b_data,
    input  logic [1:0] b_amt,
    input  logic       b_dir,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_data,
    output logic       res_id,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t     r_state;
    logic [3:0] r_data;
    logic       r_dir;
    logic       r_id;
    logic [1:0] r_cnt;
    logic       r_res_valid;
    logic [3:0] r_res_data;
    logic       r_res_id;
    logic       r_busy;

    logic       w_idle;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_accept;
    logic [3:0] w_in_data;
    logic [1:0] w_in_amt;
    logic       w_in_dir;
    logic [3:0] w_rot;

`ifdef ROT_ARB_RR_EN
    logic r_last_b;

    // A wins a tie only when B was granted last
    always_comb w_grant_a = a_valid & (~b_valid | r_last_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_b <= 1'b1;
        end else if (w_accept) begin
            r_last_b <= w_grant_b;
        end
    end
`else
    always_comb w_grant_a = a_valid;
`endif

    always_comb begin
        w_idle    = (r_state == IDLE);
        w_grant_b = b_valid & ~w_grant_a;
        w_accept  = w_idle & (w_grant_a | w_grant_b);
        w_in_data = w_grant_a ? a_data : b_data;
        w_in_amt  = w_grant_a ? a_amt  : b_amt;
        w_in_dir  = w_grant_a ? a_dir  : b_dir;
        w_rot     = r_dir ? {r_data[0], r_data[3:1]} : {r_data[2:0], r_data[3]};
    end

    assign a_ready   = w_idle & w_grant_a;
    assign b_ready   = w_idle & w_grant_b;
    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_id    = r_res_id;
    assign busy      = r_busy;

    // Result registers load only when entering DONE so they hold across SHIFT.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_data      <= '0;
            r_dir       <= 1'b0;
            r_id        <= 1'b0;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_id    <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data <= w_in_data;
                        r_dir  <= w_in_dir;
                        r_id   <= w_grant_b;
                        r_cnt  <= w_in_amt;
                        r_busy <= 1'b1;
                        if (w_in_amt == 2'd0) begin
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                            r_res_data  <= w_in_data;
                            r_res_id    <= w_grant_b;
                        end else begin
                            r_state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    r_data <= w_rot;
                    r_cnt  <= r_cnt - 2'd1;
                    if (r_cnt == 2'd1) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                        r_res_data  <= w_rot;
                        r_res_id    <= r_id;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rot_arb_seq.sv
// Self-checking bench for rot_arb_seq: per-cycle model comparison plus directed literal checks.
// Expectations for tied requests follow ROT_ARB_RR_EN when it is defined.
module tb_rot_arb_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [3:0] a_data = '0, b_data = '0;
    logic [1:0] a_amt = '0, b_amt = '0;
    logic       a_dir = 1'b0, b_dir = 1'b0;
    logic       res_ready = 1'b0;
    logic       a_ready, b_ready, res_valid, res_id, busy;
    logic [3:0] res_data;

    rot_arb_seq dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data), .a_amt(a_amt), .a_dir(a_dir),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data), .b_amt(b_amt), .b_dir(b_dir),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;
    int dut_grants[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_busy = 1'b0, m_valid = 1'b0, m_res_id = 1'b0, m_last_b = 1'b1, m_pend_id;
    logic [3:0] m_res_data = '0, m_pend;
    int         m_left;
    bit         m_id;
    int         m_k;
    logic [3:0] m_d, m_r;
    bit         m_dir;

    function automatic logic [3:0] rotl(input logic [3:0] d, input int k);
        logic [7:0] t;
        t = {d, d} << k;
        return t[7:4];
    endfunction

    function automatic bit m_grant_a();
`ifdef ROT_ARB_RR_EN
        return a_valid && (!b_valid || m_last_b);
`else
        return a_valid;
`endif
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_valid = 0; m_res_data = '0; m_res_id = 0; m_last_b = 1;
        end else if (!m_busy) begin
            if (a_valid || b_valid) begin
                m_id  = m_grant_a() ? 1'b0 : 1'b1;
                m_d   = m_id ? b_data : a_data;
                m_k   = int'(m_id ? b_amt : a_amt);
                m_dir = m_id ? b_dir : a_dir;
                m_r   = m_dir ? rotl(m_d, (4 - m_k) % 4) : rotl(m_d, m_k);
                m_busy   = 1;
                m_last_b = m_id;
                if (m_k == 0) begin
                    m_valid = 1; m_res_data = m_r; m_res_id = m_id;
                end else begin
                    m_left = m_k; m_pend = m_r; m_pend_id = m_id;
                end
            end
        end else if (!m_valid) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1; m_res_data = m_pend; m_res_id = m_pend_id;
            end
        end else if (res_ready) begin
            m_valid = 0; m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("res_valid", 32'(res_valid), 32'(m_valid));
            check("busy", 32'(busy), 32'(m_busy));
            check("res_data", 32'(res_data), 32'(m_res_data));
            check("res_id", 32'(res_id), 32'(m_res_id));
            if (!rst) begin
                check("a_ready", 32'(a_ready), 32'(!m_busy && m_grant_a()));
                check("b_ready", 32'(b_ready), 32'(!m_busy && b_valid && !m_grant_a()));
                if (a_valid && a_ready) dut_grants.push_back(0);
                else if (b_valid && b_ready) dut_grants.push_back(1);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic req(input bit id, input logic [3:0] d, input logic [1:0] k, input bit dir);
        if (id == 1'b0) begin
            a_valid = 1; a_data = d; a_amt = k; a_dir = dir;
        end else begin
            b_valid = 1; b_data = d; b_amt = k; b_dir = dir;
        end
    endtask

    task automatic drop(input bit id);
        if (id == 1'b0) a_valid = 0;
        else b_valid = 0;
    endtask

    task automatic wait_ready(input bit id, input string name);
        int w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(id ? b_ready : a_ready) && w < 30);
        check({name, "_ready_seen"}, 32'(id ? b_ready : a_ready), 32'd1);
    endtask

    task automatic wait_result(input string name, output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!res_valid && lat < 30);
        check({name, "_valid_seen"}, 32'(res_valid), 32'd1);
    endtask

    task automatic release_res();
        tick();
        res_ready = 1;
        tick();
        res_ready = 0;
    endtask

    task automatic run_job(input bit id, input logic [3:0] d, input logic [1:0] k, input bit dir,
                           input logic [3:0] exp_d, input int exp_lat, input string name);
        int lat;
        tick();
        req(id, d, k, dir);
        wait_ready(id, name);
        tick();
        drop(id);
        wait_result(name, lat);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_data"}, 32'(res_data), 32'(exp_d));
        check({name, "_id"}, 32'(res_id), 32'(id));
        release_res();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        int w;
        int cnt;
        int g_exp[4];

        rst = 1;
        tick();
        chk_en = 1;
        tick();
        @(negedge clk);
        check("reset_res_valid", 32'(res_valid), 32'd0);
        check("reset_res_data", 32'(res_data), 32'd0);
        check("reset_res_id", 32'(res_id), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        tick();
        rst = 0;

        run_job(1'b0, 4'b1001, 2'd1, 1'b0, 4'b0011, 2, "A_rotl1");
        run_job(1'b1, 4'b1001, 2'd3, 1'b1, 4'b0011, 4, "B_rotr3");

        // amt=0 result held under back-pressure while B waits
        tick();
        req(1'b0, 4'b0110, 2'd0, 1'b0);
        wait_ready(1'b0, "A_amt0");
        tick();
        drop(1'b0);
        wait_result("A_amt0", lat);
        check("A_amt0_latency", 32'(lat), 32'd1);
        tick();
        req(1'b1, 4'b1100, 2'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'b0110);
            check("hold_b_ready", 32'(b_ready), 32'd0);
        end
        tick();
        res_ready = 1;
        tick();
        res_ready = 0;
        @(negedge clk);
        check("first_idle_b_ready", 32'(b_ready), 32'd1);
        tick();
        drop(1'b1);
        wait_result("B_after_done", lat);
        check("B_after_done_latency", 32'(lat), 32'd2);
        check("B_after_done_data", 32'(res_data), 32'b0110);
        release_res();

        // continuous tie: four back-to-back jobs
        tick();
        rst = 1;
        tick();
        rst = 0;
        base = dut_grants.size();
        res_ready = 1;
        req(1'b0, 4'b0001, 2'd0, 1'b0);
        req(1'b1, 4'b0010, 2'd0, 1'b0);
        w = 0;
        while (dut_grants.size() < base + 4 && w < 100) begin
            @(negedge clk);
            w++;
        end
        tick();
        drop(1'b0);
        drop(1'b1);
        tick();
        tick();
        res_ready = 0;
        check("tie_grant_count", 32'(dut_grants.size() - base), 32'd4);
`ifdef ROT_ARB_RR_EN
        g_exp = '{0, 1, 0, 1};
`else
        g_exp = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < 4; i++) begin
            if (base + i < dut_grants.size())
                check("tie_grant_order", 32'(dut_grants[base + i]), 32'(g_exp[i]));
        end

        run_job(1'b1, 4'b0101, 2'd2, 1'b0, 4'b0101, 3, "B_alone");

        // request raised and withdrawn while busy leaves no trace
        tick();
        req(1'b0, 4'b1111, 2'd2, 1'b0);
        wait_ready(1'b0, "A_busy");
        tick();
        drop(1'b0);
        req(1'b1, 4'b1010, 2'd1, 1'b0);
        tick();
        drop(1'b1);
        wait_result("A_busy", lat);
        check("A_busy_data", 32'(res_data), 32'b1111);
        release_res();
        base = dut_grants.size();
        repeat (3) @(negedge clk);
        check("dropped_no_grant", 32'(dut_grants.size()), 32'(base));
        check("dropped_idle", 32'(busy), 32'd0);

        // reset after the first rotate of an amt=3 job
        tick();
        req(1'b0, 4'b1001, 2'd3, 1'b0);
        wait_ready(1'b0, "A_abort");
        tick();
        drop(1'b0);
        tick();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_res_valid", 32'(res_valid), 32'd0);
        check("abort_res_data", 32'(res_data), 32'd0);
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) cnt++;
        end
        check("abort_no_result", 32'(cnt), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
